// File: rtl/capture_pkg.sv
// Shared types and defaults for the multi-channel period capture block.
// Edge-mode encoding is fixed by the 2-bit per-channel edge_mode port field.
package capture_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_CH        = 2;
    localparam int DEF_WIDTH     = 24;
    localparam int DEF_FLT_WIDTH = 4;
    localparam int DEF_DEPTH     = 3;

    function automatic logic edge_qualifies(input edge_mode_e mode, input logic rise,
                                            input logic fall);
        logic q;
        q = 1'b0;
        case (mode)
            EDGE_RISE: q = rise;
            EDGE_FALL: q = fall;
            EDGE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/capture_chan.sv
// One capture channel: optional synchroniser, glitch filter, edge qualify,
// saturating period counter, period history and sticky overflow.
// Synchroniser present only when CAPTURE_SYNC_EN is defined.
module capture_chan
    import capture_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FLT_WIDTH = DEF_FLT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int VCNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         d,
    input  logic [FLT_WIDTH-1:0]         flt_val,
    input  logic [1:0]                   edge_mode,
    input  logic                         ovf_clr,
    output logic                         filtered,
    output logic                         cap_stb,
    output logic                         ovf,
    output logic [DEPTH-1:0][WIDTH-1:0]  hist,
    output logic [VCNT_W-1:0]            valid_cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic d_s;

`ifdef CAPTURE_SYNC_EN
    logic [1:0] sync_q;

    // Synchroniser runs regardless of ena so the pin is always resolved.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], d};
    end
    assign d_s = sync_q[1];
`else
    assign d_s = d;
`endif

    logic [FLT_WIDTH-1:0] flt_cnt;
    logic                 filtered_d;
    logic                 armed;
    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     cnt_inc;
    logic                 qual;
    edge_mode_e           mode;

    assign mode    = edge_mode_e'(edge_mode);
    assign qual    = edge_qualifies(mode, filtered & ~filtered_d, ~filtered & filtered_d);
    assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and block order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt    <= '0;
            filtered   <= 1'b0;
            filtered_d <= 1'b0;
        end else if (ena) begin
            filtered_d <= filtered;
            if (d_s == filtered) begin
                flt_cnt <= '0;
            end else if (flt_cnt == flt_val) begin
                filtered <= d_s;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_WIDTH'(1);
            end
        end
    end

    // NOTE: the history is cleared on reset on purpose: the read port must
    // return zeros after rst, so this storage cannot be left uninitialised.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            armed     <= 1'b0;
            cap_stb   <= 1'b0;
            ovf       <= 1'b0;
            hist      <= '0;
            valid_cnt <= '0;
        end else begin
            cap_stb <= 1'b0;
            if (mode == EDGE_OFF) begin
                armed     <= 1'b0;
                valid_cnt <= '0;
            end
            if (ena) begin
                if (qual) begin
                    cnt <= '0;
                    if (armed) begin
                        for (int k = DEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
                        hist[0] <= cnt_inc;
                        cap_stb <= 1'b1;
                        if (valid_cnt != VCNT_W'(DEPTH)) valid_cnt <= valid_cnt + VCNT_W'(1);
                    end else begin
                        armed <= 1'b1;
                    end
                end else begin
                    cnt <= cnt_inc;
                end
                // Set is evaluated after clear so it wins in the same cycle.
                if (ovf_clr) ovf <= 1'b0;
                if (armed && !qual && cnt_inc == CNT_MAX) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/capture_period_mc.sv
// Multi-channel period capture: CH independent capture_chan instances plus a
// combinational history read port. Define CAPTURE_SYNC_EN for input synchronisers.
module capture_period_mc
    import capture_pkg::*;
#(
    parameter int CH        = DEF_CH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FLT_WIDTH = DEF_FLT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      ena,
    input  logic [CH-1:0]                             d,
    input  logic [FLT_WIDTH-1:0]                      flt_val,
    input  logic [2*CH-1:0]                           edge_mode,
    input  logic [CH-1:0]                             ovf_clr,
    output logic [CH-1:0]                             filtered,
    output logic [CH-1:0]                             cap_stb,
    output logic [CH-1:0]                             ovf,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0]    rd_ch,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_idx,
    output logic [WIDTH-1:0]                          rd_data,
    output logic                                      rd_valid
);

    localparam int VCNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] hist      [CH];
    logic [VCNT_W-1:0]           valid_cnt [CH];

    for (genvar c = 0; c < CH; c++) begin : g_chan
        capture_chan #(
            .WIDTH     (WIDTH),
            .FLT_WIDTH (FLT_WIDTH),
            .DEPTH     (DEPTH),
            .VCNT_W    (VCNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .ena       (ena),
            .d         (d[c]),
            .flt_val   (flt_val),
            .edge_mode (edge_mode[2*c +: 2]),
            .ovf_clr   (ovf_clr[c]),
            .filtered  (filtered[c]),
            .cap_stb   (cap_stb[c]),
            .ovf       (ovf[c]),
            .hist      (hist[c]),
            .valid_cnt (valid_cnt[c])
        );
    end

    // NOTE: both outputs get a default before the search loop; without it an
    // unmatched rd_ch/rd_idx would leave them unassigned and infer latches.
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (int'(rd_ch) == c && int'(rd_idx) == k) begin
                    rd_data  = hist[c][k];
                    rd_valid = (k < int'(valid_cnt[c]));
                end
            end
        end
    end

endmodule

// File: tb/tb_capture_period_mc.sv
// Self-checking bench for capture_period_mc: directed scenarios plus random
// pin activity, checked against an event-level model of captured periods.
`timescale 1ns/1ps
module tb_capture_period_mc;
    import capture_pkg::*;

    localparam int CH        = 3;
    localparam int WIDTH     = 8;
    localparam int FLT_WIDTH = 4;
    localparam int DEPTH     = 3;
    localparam int SAT       = (1 << WIDTH) - 1;
`ifdef CAPTURE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst, ena;
    logic [CH-1:0]        d, ovf_clr, filtered, cap_stb, ovf;
    logic [FLT_WIDTH-1:0] flt_val;
    logic [2*CH-1:0]      edge_mode;
    logic [1:0]           rd_ch, rd_idx;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_valid;

    always #20 clk = ~clk;

    capture_period_mc #(.CH(CH), .WIDTH(WIDTH), .FLT_WIDTH(FLT_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .d(d), .flt_val(flt_val), .edge_mode(edge_mode),
        .ovf_clr(ovf_clr), .filtered(filtered), .cap_stb(cap_stb), .ovf(ovf),
        .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: capture events keyed by enabled-cycle time; periods are time differences.
    int            m_hist [CH][DEPTH];
    int            m_valid[CH];
    bit            m_armed[CH];
    int            m_last [CH];
    bit            m_ovf  [CH];
    logic [31:0]   m_sched[CH];
    logic [CH-1:0] m_dprev;
    int            now;
    int            stb_seen[CH];

    task automatic reset_model();
        for (int c = 0; c < CH; c++) begin
            m_valid[c] = 0; m_armed[c] = 0; m_last[c] = 0; m_ovf[c] = 0; m_sched[c] = '0;
            for (int k = 0; k < DEPTH; k++) m_hist[c][k] = 0;
        end
        m_dprev = '0;
    endtask

    task automatic step();
        logic [CH-1:0] exp_stb, exp_ovf;
        if (!rst && ena) begin
            for (int c = 0; c < CH; c++) begin
                logic [1:0] m;
                m = edge_mode[2*c +: 2];
                if (d[c] != m_dprev[c] &&
                    ((m == EDGE_RISE && d[c]) || (m == EDGE_FALL && !d[c]) || m == EDGE_BOTH))
                    m_sched[c][int'(flt_val) + 1 + SYNC_LAT] = 1'b1;
            end
        end
        m_dprev = d;
        @(posedge clk); #1;
        exp_stb = '0;
        if (rst) begin
            reset_model();
        end else begin
            if (ena) now++;
            for (int c = 0; c < CH; c++) begin
                if (edge_mode[2*c +: 2] == EDGE_OFF) begin
                    m_armed[c] = 0;
                    m_valid[c] = 0;
                end
                if (ena) begin
                    if (ovf_clr[c]) m_ovf[c] = 0;
                    if (m_sched[c][0]) begin
                        if (m_armed[c]) begin
                            for (int k = DEPTH - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                            m_hist[c][0] = (now - m_last[c] > SAT) ? SAT : now - m_last[c];
                            if (m_valid[c] < DEPTH) m_valid[c]++;
                            exp_stb[c] = 1'b1;
                        end else begin
                            m_armed[c] = 1;
                        end
                        m_last[c] = now;
                    end
                    m_sched[c] = m_sched[c] >> 1;
                    if (m_armed[c] && now - m_last[c] >= SAT) m_ovf[c] = 1;
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            exp_ovf[c] = m_ovf[c];
            if (cap_stb[c]) stb_seen[c]++;
        end
        check("cap_stb", 32'(cap_stb), 32'(exp_stb));
        check("ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; d = '0; ovf_clr = '0;
        run(2);
        rst = 1'b0;
    endtask

    task automatic rd(input int ch, input int idx, output logic [WIDTH-1:0] data,
                      output logic valid);
        rd_ch = 2'(ch); rd_idx = 2'(idx);
        #1;
        data = rd_data; valid = rd_valid;
    endtask

    task automatic check_reads();
        logic [WIDTH-1:0] v;
        logic             ok;
        for (int c = 0; c <= CH; c++) begin
            for (int k = 0; k <= DEPTH; k++) begin
                rd(c, k, v, ok);
                if (c < CH && k < DEPTH) begin
                    check($sformatf("rd_data[%0d][%0d]", c, k), 32'(v), 32'(m_hist[c][k]));
                    check($sformatf("rd_valid[%0d][%0d]", c, k), 32'(ok), 32'(k < m_valid[c]));
                end else begin
                    check($sformatf("rd_data_oob[%0d][%0d]", c, k), 32'(v), 32'd0);
                    check($sformatf("rd_valid_oob[%0d][%0d]", c, k), 32'(ok), 32'd0);
                end
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        logic             ok;
        logic [CH-1:0]    first_stb;
        int               lat, seen, hold[CH];

        rst = 1'b1; ena = 1'b1; d = '0; flt_val = 4'd3; edge_mode = '0; ovf_clr = '0;
        rd_ch = '0; rd_idx = '0; now = 0;
        for (int c = 0; c < CH; c++) stb_seen[c] = 0;
        reset_model();

        // Reset state
        do_reset();
        check("rst_filtered", 32'(filtered), 32'd0);
        check_reads();

        // Filter: 3-cycle glitch rejected, 4-cycle pulse passes with fixed latency
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            d[0] = (k < 3);
            step();
            if (filtered[0]) seen = 1;
        end
        check("glitch_filtered", 32'(seen), 32'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            d[0] = (k <= 4);
            step();
            if (filtered[0] && lat == 0) lat = k;
        end
        check("flt_latency", 32'(lat), 32'(3 + 1 + SYNC_LAT));
        run(10);

        // Rise mode, edges 10 apart x4
        edge_mode = 6'b000001;
        stb_seen[0] = 0;
        for (int e = 0; e < 4; e++) begin
            d[0] = 1'b1; run(5);
            d[0] = 1'b0; run(5);
        end
        run(12);
        check("rise_stb_count", 32'(stb_seen[0]), 32'd3);
        for (int k = 0; k < DEPTH; k++) begin
            rd(0, k, v, ok);
            check($sformatf("rise_hist%0d", k), 32'(v), 32'd10);
            check($sformatf("rise_valid%0d", k), 32'(ok), 32'd1);
        end
        check_reads();

        // Both-edge mode: high 7, low 5
        do_reset();
        edge_mode = 6'b001100;
        d[1] = 1'b1; run(7);
        d[1] = 1'b0; run(5);
        d[1] = 1'b1; run(12);
        rd(1, 0, v, ok); check("both_hist0", 32'(v), 32'd5);
        rd(1, 1, v, ok); check("both_hist1", 32'(v), 32'd7);
        check_reads();

        // Enable freeze between rising edges 10 enabled cycles apart
        do_reset();
        flt_val = 4'd1;
        edge_mode = 6'b000100;
        d[1] = 1'b1; run(4);
        d[1] = 1'b0; run(3);
        ena = 1'b0;  run(20);
        ena = 1'b1;  run(3);
        d[1] = 1'b1; run(10);
        rd(1, 0, v, ok); check("ena_period", 32'(v), 32'd10);
        check_reads();

        // Reset mid-count and mid-filter; next edge is arm-only
        flt_val = 4'd3;
        d[1] = 1'b0; run(5);
        d[0] = 1'b1; run(2);
        do_reset();
        run(8);
        check("rst_mid_filtered", 32'(filtered), 32'd0);
        check_reads();
        stb_seen[1] = 0;
        d[1] = 1'b1; run(12);
        check("rst_arm_only", 32'(stb_seen[1]), 32'd0);
        d[1] = 1'b0; run(5);
        d[1] = 1'b1; run(12);
        check("rst_next_capture", 32'(stb_seen[1]), 32'd1);
        rd(1, 0, v, ok); check("rst_next_period", 32'(v), 32'd17);

        // Overflow: WIDTH=8 saturates at 255
        do_reset();
        flt_val = 4'd2;
        edge_mode = 6'b010000;
        d[2] = 1'b1; run(300);
        check("ovf_held", 32'(ovf[2]), 32'd1);
        ovf_clr = 3'b100; step(); ovf_clr = '0;
        check("ovf_clr_vs_sat", 32'(ovf[2]), 32'd1);
        d[2] = 1'b0; run(5);
        d[2] = 1'b1; run(10);
        rd(2, 0, v, ok); check("ovf_period", 32'(v), 32'(SAT));
        check("ovf_sticky", 32'(ovf[2]), 32'd1);
        ovf_clr = 3'b100; step(); ovf_clr = '0;
        check("ovf_cleared", 32'(ovf[2]), 32'd0);

        // Read bounds and simultaneous captures on ch0/ch2
        rd(3, 0, v, ok);
        check("oob_ch_data", 32'(v), 32'd0);
        check("oob_ch_valid", 32'(ok), 32'd0);
        do_reset();
        flt_val = 4'd0;
        edge_mode = 6'b010001;
        d = 3'b101; run(6);
        d = 3'b000; run(6);
        d = 3'b101;
        first_stb = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (first_stb == '0) first_stb = cap_stb;
        end
        check("simul_stb", 32'(first_stb), 32'b101);
        check_reads();

        // Random pin activity per channel with random modes and filter length
        for (int r = 0; r < 3; r++) begin
            do_reset();
            flt_val = 4'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++) begin
                edge_mode[2*c +: 2] = 2'($urandom_range(1, 3));
                hold[c] = $urandom_range(6, 40);
            end
            for (int cyc = 0; cyc < 500; cyc++) begin
                for (int c = 0; c < CH; c++) begin
                    if (hold[c] == 0) begin
                        d[c] = ~d[c];
                        hold[c] = $urandom_range(6, 40);
                    end else begin
                        hold[c]--;
                    end
                end
                ovf_clr = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
                step();
            end
            ovf_clr = '0;
            run(20);
            check_reads();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_period_mc.md
CAPTURE_PERIOD_MC -- requirements
Module: capture_period_mc

Interface
REQ-001 SHALL have parameter CH, default 2, number of capture channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 24, period/timestamp counter width.
REQ-003 SHALL have parameter FLT_WIDTH, default 4, filter counter width.
REQ-004 SHALL have parameter DEPTH, default 3, period history depth per channel (1..8).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: ena in 1 global enable; d in CH raw pins; flt_val in FLT_WIDTH filter length, shared by all channels.
REQ-007 SHALL have ports: edge_mode in 2*CH, 2 bits per channel (00 off, 01 rise, 10 fall, 11 both); ovf_clr in CH, per-channel overflow clear.
REQ-008 SHALL have ports: filtered out CH; cap_stb out CH, 1-cycle capture pulse; ovf out CH, sticky overflow flag.
REQ-009 SHALL have read ports: rd_ch in clog2(CH); rd_idx in clog2(DEPTH); rd_data out WIDTH; rd_valid out 1.

Function
REQ-010 SHALL count consecutive cycles in which the synchronised input differs from filtered; the counter restarts at 0 on any match.
REQ-011 SHALL update filtered the cycle after the mismatch count reaches flt_val; flt_val=0 gives 1 cycle of filter latency.
REQ-012 SHALL detect qualifying edges from filtered versus its 1-cycle-delayed copy, per edge_mode; mode 00 never qualifies.
REQ-013 SHALL maintain a per-channel period counter that increments each enabled cycle and saturates at 2^WIDTH-1.
REQ-014 SHALL, on a qualifying edge, load sat(cnt+1) into hist[0], shift hist[k] to hist[k+1], discard hist[DEPTH-1], and load cnt with 0.
REQ-015 SHALL assert cap_stb one cycle after filtered toggles, in the same cycle the history update becomes visible.
REQ-016 SHALL treat the first qualifying edge after reset or after a mode change from 00 as arm-only: cnt loads 0, no push, no cap_stb.
REQ-017 SHALL keep a per-channel valid count saturating at DEPTH; rd_valid = (rd_idx < valid count) and rd_ch < CH.
REQ-018 SHALL drive rd_data combinationally as hist[rd_ch][rd_idx]; out-of-range rd_ch or rd_idx gives rd_data=0 and rd_valid=0.
REQ-019 SHALL set ovf when cnt reaches saturation while armed; ovf SHALL clear only on ovf_clr, and set wins if both occur in the same cycle.
REQ-020 SHALL freeze filter counters, filtered, period counters, history and ovf while ena=0; cap_stb SHALL be 0 and edges during ena=0 SHALL be lost.
REQ-021 SHALL apply an edge_mode change from the next cycle; a change to 00 SHALL disarm the channel and zero its valid count.
REQ-022 SHALL keep channels fully independent; simultaneous edges on several channels SHALL all be captured in the same cycle.

Reset
REQ-023 SHALL, on rst, clear filtered, cap_stb, ovf, all counters, history and valid counts to 0 and disarm all channels; rst SHALL override ena.
REQ-024 SHALL abort any filter count in progress on rst mid-operation; no partial capture SHALL survive.

Configuration
REQ-025 SHALL include a 2-flop input synchroniser per channel when CAPTURE_SYNC_EN is defined; d-to-filtered latency is then flt_val+3 cycles.
REQ-026 SHALL feed d directly to the filter when CAPTURE_SYNC_EN is undefined; d-to-filtered latency is then flt_val+1 cycles and all other behaviour is unchanged.

Structure
REQ-027 SHALL place the edge-mode enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and default parameter constants in package capture_pkg.
REQ-028 SHALL implement per-channel logic in sub-module capture_chan, instantiated CH times by a generate loop; the read mux SHALL live in the top.

Verification
REQ-029 SHALL verify the filter: flt_val=3, a 3-cycle glitch on d[0] -> filtered unchanged; a 4-cycle pulse -> filtered toggles, latency 6 with CAPTURE_SYNC_EN.
REQ-030 SHALL verify rise mode: rising edges 10 cycles apart, x4 -> first edge arm-only, then 3 cap_stb pulses; hist = {10,10,10}, valid count = 3.
REQ-031 SHALL verify both-edge mode: high 7 cycles, low 5 cycles -> hist[0]=5, hist[1]=7 after the third edge.
REQ-032 SHALL verify overflow: WIDTH=8, armed, no edge for 300 cycles -> ovf=1 held; next edge stores 255; ovf_clr and saturation in the same cycle -> ovf stays 1.
REQ-033 SHALL verify enable and reset: ena=0 for 20 cycles between edges 10 apart -> stored period 10; rst mid-count -> all outputs 0, next edge arm-only.
REQ-034 SHALL verify read-port bounds: CH=3, rd_ch=3 -> rd_data=0, rd_valid=0; simultaneous edges on ch0 and ch2 -> both cap_stb pulses in the same cycle.
